// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter with burst limiting; the registered one-hot
// grant also selects the shared 4:1 AND-OR data mux.
module rr_mux_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] req_i,
  input  logic [3:0] a_i,
  output logic [3:0] grant_o,
  output logic [1:0] owner_o,
  output logic       busy_o,
  output logic       y_o,
  output logic       dbg_state_o,
  output logic [1:0] dbg_ptr_o,
  output logic [3:0] dbg_cnt_o
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;

  logic [3:0] others;
  logic [2:0] pick_idle;
  logic [2:0] pick_next;
  logic       take;
  logic [1:0] win;

  // Returns {found, index} of the first set bit searching upward from start, modulo 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    take      = 1'b0;
    win       = 2'd0;
    others    = req_i & ~grant_q;
    pick_idle = rr_pick(req_i, ptr_q);
    pick_next = rr_pick(others, owner_q + 2'd1);

    case (state_q)
      IDLE: begin
        if (pick_idle[2]) begin
          take = 1'b1;
          win  = pick_idle[1:0];
        end
      end
      GRANT: begin
        if (!req_i[owner_q]) begin
          if (pick_next[2]) begin
            take = 1'b1;
            win  = pick_next[1:0];
          end else begin
            state_d = IDLE;
            grant_d = 4'b0000;
            owner_d = 2'd0;
            cnt_d   = 4'd0;
          end
        end else if (cnt_q < MAX_CNT) begin
          cnt_d = cnt_q + 4'd1;
        end else if (pick_next[2]) begin
          take = 1'b1;
          win  = pick_next[1:0];
        end else begin
          // Sole requester at the burst limit keeps the grant with a fresh burst.
          cnt_d = 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      state_d = GRANT;
      grant_d = 4'b0001 << win;
      owner_d = win;
      cnt_d   = 4'd1;
      ptr_d   = win + 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o     = grant_q;
  assign owner_o     = owner_q;
  assign busy_o      = (state_q == GRANT);
  // Mux path is purely combinational from the registered select.
  assign y_o         = |(grant_q & a_i);
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;
  assign dbg_cnt_o   = cnt_q;

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4, maximum consecutive grant cycles for one requester while others wait; legal range 1..15.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 reset_i  input  1  asynchronous active-high reset.
REQ-005 req_i  input  4  per-requester request; bit k is requester k.
REQ-006 a_i  input  4  per-requester data bit; bit k belongs to requester k.
REQ-007 grant_o  output  4  registered one-hot grant, doubling as the shared 4:1 mux select; 4'b0000 when idle.
REQ-008 owner_o  output  2  binary index of the granted requester; 2'd0 when idle.
REQ-009 busy_o  output  1  high while any grant is held.
REQ-010 y_o  output  1  shared mux output, the AND-OR of grant_o and a_i, i.e. OR over k of (grant_o[k] & a_i[k]).

Function
REQ-011 The FSM SHALL have exactly two states, IDLE and GRANT, plus internal registers ptr[1:0] (rotating priority start) and cnt[3:0] (burst count).
REQ-012 Arbitration SHALL search req_i from index ptr upward, modulo 4; the first set bit wins.
REQ-013 IDLE, req_i==0: remain IDLE; grant_o=0, busy_o=0.
REQ-014 IDLE, req_i!=0: next cycle enter GRANT with the winner granted, cnt=1, ptr=winner+1 mod 4; one-cycle request-to-grant latency.
REQ-015 GRANT, owner request dropped, other requests pending: next cycle grant the winner searched from owner+1, cnt=1, ptr=winner+1; grant_o never 0 between owners.
REQ-016 GRANT, owner request dropped, no other request: next cycle return to IDLE, grant_o=0, ptr unchanged.
REQ-017 GRANT, owner held, cnt<MAX_BURST: keep owner; cnt increments by 1.
REQ-018 GRANT, owner held, cnt==MAX_BURST, another request pending: next cycle switch to the winner searched from owner+1 (owner excluded), cnt=1, ptr=winner+1.
REQ-019 GRANT, owner held, cnt==MAX_BURST, no other request: keep owner; cnt reloads to 1.
REQ-020 cnt SHALL never exceed MAX_BURST and SHALL never wrap.
REQ-021 grant_o SHALL be one-hot or zero in every cycle; owner_o SHALL equal the encoded grant_o; busy_o SHALL equal (grant_o != 0).
REQ-022 y_o SHALL be combinational from the registered grant_o and the current a_i, with zero added latency; y_o=0 when idle.
REQ-023 A request rising and falling within one cycle while another requester owns the grant SHALL be ignored; no request is latched.

Reset
REQ-024 Asserting reset_i SHALL immediately force: state IDLE, grant_o=0, owner_o=0, busy_o=0, y_o=0, ptr=0, cnt=0, without waiting for a clock edge.
REQ-025 Reset asserted mid-burst SHALL discard the owner and count; after release, arbitration restarts from ptr=0.
REQ-026 The first rising edge after reset_i deasserts SHALL evaluate req_i as in IDLE.

Verification
REQ-027 After reset, req_i=4'b1010 held, MAX_BURST=4 -> grant_o=4'b0010 one cycle later for 4 cycles, then 4'b1000 for 4 cycles, then 4'b0010 again.
REQ-028 req_i=4'b0100 only, held 10 cycles -> grant_o=4'b0100 continuously and busy_o=1 throughout; cnt reloads at 4 with no gap.
REQ-029 Owner 0 granted, req_i changes from 4'b0011 to 4'b0010 -> next cycle grant_o=4'b0010 with no idle cycle; then req_i=0 -> grant_o=0 and busy_o=0 one cycle later.
REQ-030 grant_o=4'b1000, a_i toggling 0/1 each cycle -> y_o follows a_i[3] in the same cycle; changes on a_i[2:0] do not affect y_o.
REQ-031 Reset asserted asynchronously mid-burst with grant_o=4'b0100 -> all outputs 0 before the next clock edge; after release with req_i=4'b1111 -> grant_o=4'b0001.
REQ-032 Random req_i for 10000 cycles -> grant_o always one-hot or zero, and no requester held continuously waits more than 3*MAX_BURST+1 cycles.
